// File: rtl/control_core.sv
// Fetch-PC sequencer, register file and issue scoreboard for a small RV32 core.
// Optional macro CONTROL_BYPASS_EN forwards same-cycle writeback data to the issue operands.
module control_core #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [31:0] fetch_req_pc,
  output logic        fetch_req_epoch,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic        iss_epoch,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  output logic [31:0] iss_rs1_data,
  output logic [31:0] iss_rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        err_reg,
  output logic        err_align
);

  localparam int AW = $clog2(NUM_REGS);

  logic [31:0]         pc_q, pc_d;
  logic                epoch_q, epoch_d;
  logic                err_reg_q, err_reg_d;
  logic                err_align_q, err_align_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];

  logic [31:0] busy_ext;
  logic        rs1_ok, rs2_ok, rd_ok, wb_ok;
  logic        fwd1, fwd2, hazard, stale, accept_cur, handshake, redir_ok;
  logic [31:0] rs1_rf, rs2_rf;

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Out-of-range indices land on the zero-extended upper bits, so they are never busy.
  assign busy_ext = 32'(busy_q);

  assign rs1_ok = in_range(iss_rs1) && (iss_rs1 != 5'd0);
  assign rs2_ok = in_range(iss_rs2) && (iss_rs2 != 5'd0);
  assign rd_ok  = in_range(iss_rd)  && (iss_rd  != 5'd0);
  assign wb_ok  = wb_valid && in_range(wb_rd) && (wb_rd != 5'd0);

  always_comb begin
    rs1_rf = '0;
    rs2_rf = '0;
    if (rs1_ok) rs1_rf = regs_q[iss_rs1[AW-1:0]];
    if (rs2_ok) rs2_rf = regs_q[iss_rs2[AW-1:0]];
  end

`ifdef CONTROL_BYPASS_EN
  assign fwd1 = wb_ok && (wb_rd == iss_rs1);
  assign fwd2 = wb_ok && (wb_rd == iss_rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign iss_rs1_data = fwd1 ? wb_data : rs1_rf;
  assign iss_rs2_data = fwd2 ? wb_data : rs2_rf;

  assign hazard     = (busy_ext[iss_rs1] & ~fwd1) | (busy_ext[iss_rs2] & ~fwd2) | busy_ext[iss_rd];
  assign stale      = (iss_epoch != epoch_q);
  assign iss_ready  = stale | ~hazard;
  assign accept_cur = iss_valid && !stale && !hazard;

  // Valid follows reset directly so it drops in the reset cycle and rises as soon as reset is released.
  assign fetch_req_valid = reset;
  assign fetch_req_pc    = pc_q;
  assign fetch_req_epoch = epoch_q;
  assign err_reg         = err_reg_q;
  assign err_align       = err_align_q;

  assign handshake = fetch_req_valid && fetch_req_ready;
  assign redir_ok  = redir_valid && (redir_pc[1:0] == 2'b00);

  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    err_reg_d   = err_reg_q;
    err_align_d = err_align_q;
    busy_d      = busy_q;
    regs_d      = regs_q;

    if (redir_ok) begin
      pc_d    = redir_pc;
      epoch_d = ~epoch_q;
    end else if (handshake) begin
      pc_d = pc_q + 32'd4;
    end
    if (redir_valid && !redir_ok) err_align_d = 1'b1;

    if (wb_valid && !in_range(wb_rd)) err_reg_d = 1'b1;
    if (accept_cur && !(in_range(iss_rs1) && in_range(iss_rs2) && in_range(iss_rd)))
      err_reg_d = 1'b1;

    // Clear before set so a same-cycle issue to the written register keeps it busy.
    if (wb_ok) begin
      regs_d[wb_rd[AW-1:0]] = wb_data;
      busy_d[wb_rd[AW-1:0]] = 1'b0;
    end
    if (accept_cur && rd_ok) busy_d[iss_rd[AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      epoch_q     <= 1'b0;
      err_reg_q   <= 1'b0;
      err_align_q <= 1'b0;
      busy_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      err_reg_q   <= err_reg_d;
      err_align_q <= err_align_d;
      busy_q      <= busy_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_control_core.sv
// Directed bench for control_core (NUM_REGS=16, RESET_PC=32'h100); follows CONTROL_BYPASS_EN if defined.
module tb_control_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req_valid, fetch_req_ready;
  logic [31:0] fetch_req_pc;
  logic        fetch_req_epoch;
  logic        iss_valid, iss_ready, iss_epoch;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [31:0] iss_rs1_data, iss_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        err_reg, err_align;

  int total = 0;
  int bad   = 0;

  control_core #(.NUM_REGS(16), .RESET_PC(32'h100)) dut (
    .clock(clock), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_pc(fetch_req_pc), .fetch_req_epoch(fetch_req_epoch),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_epoch(iss_epoch),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .err_reg(err_reg), .err_align(err_align)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; fetch_req_ready = 1'b0;
    iss_valid = 1'b0; iss_epoch = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    redir_valid = 1'b0; redir_pc = '0;

    // Reset and sequential fetch
    step(); step();
    check_val("rst_valid", 32'(fetch_req_valid), 32'd0);
    check_val("rst_pc", fetch_req_pc, 32'h100);
    reset = 1'b1; settle();
    check_val("post_valid", 32'(fetch_req_valid), 32'd1);
    check_val("post_epoch", 32'(fetch_req_epoch), 32'd0);
    check_val("post_err_reg", 32'(err_reg), 32'd0);
    check_val("post_err_align", 32'(err_align), 32'd0);
    fetch_req_ready = 1'b1; settle();
    check_val("pc0", fetch_req_pc, 32'h100);
    step(); check_val("pc1", fetch_req_pc, 32'h104);
    step(); check_val("pc2", fetch_req_pc, 32'h108);
    fetch_req_ready = 1'b0;
    step(); check_val("pc_hold", fetch_req_pc, 32'h108);

    // RAW hazard on x5 resolved by writeback
    iss_valid = 1'b1; iss_epoch = 1'b0; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd5; settle();
    check_val("iss_rd5_ready", 32'(iss_ready), 32'd1);
    step();
    iss_rs1 = 5'd5; iss_rd = 5'd6; settle();
    check_val("raw_wait0", 32'(iss_ready), 32'd0);
    step(); check_val("raw_wait1", 32'(iss_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD; settle();
`ifdef CONTROL_BYPASS_EN
    check_val("byp_ready", 32'(iss_ready), 32'd1);
    check_val("byp_data", iss_rs1_data, 32'hDEAD);
    step();
    wb_valid = 1'b0; iss_valid = 1'b0;
`else
    check_val("wb_cycle_ready", 32'(iss_ready), 32'd0);
    step();
    wb_valid = 1'b0; settle();
    check_val("after_wb_ready", 32'(iss_ready), 32'd1);
    check_val("after_wb_data", iss_rs1_data, 32'hDEAD);
    step();
    iss_valid = 1'b0;
`endif

    // Aligned redirect with ready low; stale issue ignores hazard
    redir_valid = 1'b1; redir_pc = 32'h200;
    step();
    redir_valid = 1'b0; settle();
    check_val("redir_pc", fetch_req_pc, 32'h200);
    check_val("redir_epoch", 32'(fetch_req_epoch), 32'd1);
    iss_valid = 1'b1; iss_epoch = 1'b0; iss_rs1 = 5'd6; iss_rs2 = 5'd0; iss_rd = 5'd7; settle();
    check_val("stale_ready", 32'(iss_ready), 32'd1);
    step();
    iss_epoch = 1'b1; iss_rs1 = 5'd7; iss_rd = 5'd0; settle();
    check_val("stale_no_busy7", 32'(iss_ready), 32'd1);
    iss_rs1 = 5'd6; settle();
    check_val("busy6_kept", 32'(iss_ready), 32'd0);
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    step();
    wb_valid = 1'b0; settle();
    check_val("x6_data", iss_rs1_data, 32'h66);
    check_val("x6_free", 32'(iss_ready), 32'd1);

    // Misaligned redirect
    redir_valid = 1'b1; redir_pc = 32'h202;
    step();
    redir_valid = 1'b0; settle();
    check_val("mis_pc", fetch_req_pc, 32'h200);
    check_val("mis_epoch", 32'(fetch_req_epoch), 32'd1);
    check_val("mis_err", 32'(err_align), 32'd1);
    step(); step();
    check_val("mis_err_sticky", 32'(err_align), 32'd1);

    // Illegal index and x0 writes
    check_val("err_reg_pre", 32'(err_reg), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'd1;
    step();
    wb_valid = 1'b0; iss_rs1 = 5'd20; settle();
    check_val("err_reg_set", 32'(err_reg), 32'd1);
    check_val("x20_read", iss_rs1_data, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'd7;
    step();
    wb_valid = 1'b0; iss_rs1 = 5'd0; settle();
    check_val("x0_read", iss_rs1_data, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    step();
    wb_valid = 1'b0; iss_rs2 = 5'd3; settle();
    check_val("x3_rs2", iss_rs2_data, 32'h33);
    iss_rs2 = 5'd0;

    // PC wrap, redirect beating handshake
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step();
    redir_valid = 1'b0; settle();
    check_val("wrap_pre_pc", fetch_req_pc, 32'hFFFF_FFFC);
    check_val("wrap_pre_epoch", 32'(fetch_req_epoch), 32'd0);
    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready = 1'b0; settle();
    check_val("wrap_pc", fetch_req_pc, 32'h0);
    redir_valid = 1'b1; redir_pc = 32'h40; fetch_req_ready = 1'b1;
    step();
    redir_valid = 1'b0; fetch_req_ready = 1'b0; settle();
    check_val("redir_wins_pc", fetch_req_pc, 32'h40);
    check_val("redir_wins_epoch", 32'(fetch_req_epoch), 32'd1);

    // Reset with busy[3] set
    iss_valid = 1'b1; iss_epoch = 1'b1; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd3; settle();
    check_val("busy3_accept", 32'(iss_ready), 32'd1);
    step();
    iss_valid = 1'b0; iss_rs1 = 5'd3; iss_rd = 5'd0; settle();
    check_val("busy3_set", 32'(iss_ready), 32'd0);
    reset = 1'b0; settle();
    check_val("mid_rst_valid", 32'(fetch_req_valid), 32'd0);
    step();
    reset = 1'b1; iss_epoch = 1'b0; settle();
    check_val("rst2_valid", 32'(fetch_req_valid), 32'd1);
    check_val("rst2_pc", fetch_req_pc, 32'h100);
    check_val("rst2_epoch", 32'(fetch_req_epoch), 32'd0);
    check_val("rst2_busy3", 32'(iss_ready), 32'd1);
    check_val("rst2_x3", iss_rs1_data, 32'd0);
    check_val("rst2_err_reg", 32'(err_reg), 32'd0);
    check_val("rst2_err_align", 32'(err_align), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
